vpu_host_if_bridge: RTL and testbench
=====================================

Name: vpu_host_if_bridge

Overview:
- Parametrised host-side front end that sits between the host REQ/RESPONSE handshakes and the VPU_TOP_WRAPPER core.
- Buffers host instructions in a request FIFO.
- Enforces a per-stream cap on outstanding instructions.
- Buffers core completions in a response FIFO so that host backpressure never stalls the core.
- Exposes occupancy and error status.

Parameters:
- STREAM_ID_WIDTH, 2, stream ID width; NUM_STREAMS = 2**STREAM_ID_WIDTH.
- REQ_FIFO_DEPTH, 4, request FIFO entries; power of 2, ≥ 2.
- REQ_FIFO_DEPTH_LG2, 2, $clog2(REQ_FIFO_DEPTH).
- RSP_FIFO_DEPTH, 4, response FIFO entries; power of 2, ≥ 2.
- RSP_FIFO_DEPTH_LG2, 2, $clog2(RSP_FIFO_DEPTH).
- MAX_OUTSTANDING, 3, maximum issued-but-uncompleted instructions per stream; 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- host_valid_i  in  1  host request valid
- host_ready_o  out  1  bridge can accept a request
- host_opcode_i  in  8  opcode
- host_dst0_i / host_src0_i / host_src1_i / host_src2_i / host_imm_i  in  24 each  operand fields
- host_stream_id_i  in  STREAM_ID_WIDTH  request stream
- host_rsp_valid_o  out  1  completion available to host
- host_rsp_stream_id_o  out  STREAM_ID_WIDTH  completed stream
- host_rsp_ready_i  in  1  host accepts completion
- core_valid_o  out  1  request to core valid
- core_ready_i  in  1  core ready_o
- core_opcode_o  out  8  opcode
- core_dst0_o / core_src0_o / core_src1_o / core_src2_o / core_imm_o  out  24 each  operand fields
- core_stream_id_o  out  STREAM_ID_WIDTH  stream to core
- core_rsp_valid_i  in  1  core valid_o
- core_rsp_stream_id_i  in  STREAM_ID_WIDTH  core stream_id_o
- core_rsp_ready_o  out  1  drives core ready_i
- req_count_o  out  REQ_FIFO_DEPTH_LG2+1  request FIFO occupancy
- busy_o  out  1  any FIFO non-empty or any stream outstanding
- err_o  out  1  sticky protocol error

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - All FIFO pointers and occupancy counts 0; all per-stream outstanding counters 0; err_o 0.
  - host_ready_o 1, core_valid_o 0, host_rsp_valid_o 0, core_rsp_ready_o 1, busy_o 0, req_count_o 0.
  - Payload outputs are don't-care while their valid is low.
- Reset mid-operation clears all state immediately; in-flight entries are discarded. No completion is generated for them.
- All transfers follow valid/ready: a transfer occurs on a rising edge with valid && ready. A valid, once high, holds with stable payload until accepted.
- Request FIFO:
  - Entry width is 128+STREAM_ID_WIDTH bits.
  - host_ready_o = (req_count < REQ_FIFO_DEPTH). It depends only on occupancy, not on core_ready_i.
  - First-word fall-through from registered storage: a push in cycle N is visible on core_* in cycle N+1 at the earliest. There is no combinational host-to-core path.
  - Simultaneous push and pop when 0 < count < DEPTH leaves count unchanged. Pointers wrap modulo DEPTH.
- Issue gate:
  - core_valid_o = !req_empty && (outstanding[head.stream_id] < MAX_OUTSTANDING).
  - A blocked head blocks all younger entries; ordering is strict, with no bypass.
  - On issue, outstanding[head.stream_id] increments by 1.
- Completion path:
  - core_rsp_ready_o = (rsp_count < RSP_FIFO_DEPTH).
  - On core_rsp_valid_i && core_rsp_ready_o:
    - push core_rsp_stream_id_i;
    - decrement outstanding[core_rsp_stream_id_i].
  - If that counter is 0 at the time of the completion: set err_o (sticky until reset), leave the counter at 0, and still push the entry.
- Same-cycle issue and completion on the same stream: the counter is unchanged. On different streams, each counter updates independently.
- Completion unblocking: a completion in cycle N that drops a counter below the cap permits issue for that stream in cycle N+1. Counters are registered; there is no same-cycle bypass.
- Response FIFO:
  - host_rsp_valid_o = !rsp_empty; host_rsp_stream_id_o = head entry.
  - Same FWFT and latency rules as the request FIFO. Completion order is preserved exactly.
- busy_o = !req_empty || !rsp_empty || OR of (outstanding[s] != 0), computed combinationally from registers.

Test Plan:
- Reset-to-idle: reset, then a single request (opcode 0x11, stream 1, core_ready_i=1) → core_valid_o rises in cycle N+1 with identical fields. Returning completion stream 1 → host_rsp_valid_o in the following cycle with stream_id 1. After the host accepts, busy_o=0.
- Request FIFO fill: core_ready_i=0, push 4 requests → req_count_o=4 and host_ready_o=0 on the cycle after the 4th accept. Release core_ready_i → 4 issues in push order, host_ready_o=1 after the first pop.
- Outstanding cap: MAX_OUTSTANDING=3, push 5 stream-2 requests, no completions → exactly 3 issue, then core_valid_o=0. One stream-2 completion → the 4th issues the next cycle.
- Head-of-line blocking: stream 0 at cap, queue [stream 0, stream 3] → stream 3 does not issue until a stream-0 completion arrives.
- Backpressure and simultaneous events: host_rsp_ready_i=0 with 4 completions → core_rsp_ready_o=0. Then a same-cycle issue and completion on stream 1 → outstanding[1] unchanged.
- Error plus async reset: completion for stream 3 with outstanding 0 → err_o=1 and an entry is pushed. Assert rst_n=0 mid-burst → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/vpu_host_if_bridge.sv
// ---------------------------------------------------------------------------
// vpu_host_if_bridge
//
// Host-side front end for the VPU core. It sits between the host request and
// response handshakes and the core.
//   - Host instructions wait in a request FIFO. The FIFO is first-word
//     fall-through from registered storage, so there is no combinational
//     host-to-core path.
//   - The FIFO head issues to the core only while its stream has fewer than
//     MAX_OUTSTANDING instructions in flight. A blocked head also holds back
//     every younger entry.
//   - Core completions go into a response FIFO. Because of this, host
//     backpressure never stalls the core directly.
//   - A completion that arrives for a stream with nothing outstanding sets
//     a sticky error flag.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   host_valid_i/host_ready_o  host request handshake
//   host_opcode_i, host_*_i    request opcode and 24-bit operand fields
//   host_stream_id_i           request stream
//   host_rsp_valid_o/_ready_i  completion handshake towards the host
//   host_rsp_stream_id_o       stream of the oldest buffered completion
//   core_valid_o/core_ready_i  issue handshake towards the core
//   core_opcode_o, core_*_o    issued opcode, operands and stream
//   core_rsp_valid_i/_ready_o  completion handshake from the core
//   core_rsp_stream_id_i       stream of the completing instruction
//   req_count_o                request FIFO occupancy
//   busy_o                     any FIFO non-empty or any stream in flight
//   err_o                      sticky completion-without-issue error
// ---------------------------------------------------------------------------
module vpu_host_if_bridge #(
    parameter int STREAM_ID_WIDTH    = 2,
    parameter int REQ_FIFO_DEPTH     = 4,
    parameter int REQ_FIFO_DEPTH_LG2 = 2,
    parameter int RSP_FIFO_DEPTH     = 4,
    parameter int RSP_FIFO_DEPTH_LG2 = 2,
    parameter int MAX_OUTSTANDING    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          host_valid_i,
    output logic                          host_ready_o,
    input  logic [7:0]                    host_opcode_i,
    input  logic [23:0]                   host_dst0_i,
    input  logic [23:0]                   host_src0_i,
    input  logic [23:0]                   host_src1_i,
    input  logic [23:0]                   host_src2_i,
    input  logic [23:0]                   host_imm_i,
    input  logic [STREAM_ID_WIDTH-1:0]    host_stream_id_i,

    output logic                          host_rsp_valid_o,
    output logic [STREAM_ID_WIDTH-1:0]    host_rsp_stream_id_o,
    input  logic                          host_rsp_ready_i,

    output logic                          core_valid_o,
    input  logic                          core_ready_i,
    output logic [7:0]                    core_opcode_o,
    output logic [23:0]                   core_dst0_o,
    output logic [23:0]                   core_src0_o,
    output logic [23:0]                   core_src1_o,
    output logic [23:0]                   core_src2_o,
    output logic [23:0]                   core_imm_o,
    output logic [STREAM_ID_WIDTH-1:0]    core_stream_id_o,

    input  logic                          core_rsp_valid_i,
    input  logic [STREAM_ID_WIDTH-1:0]    core_rsp_stream_id_i,
    output logic                          core_rsp_ready_o,

    output logic [REQ_FIFO_DEPTH_LG2:0]   req_count_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int NUM_STREAMS = 2 ** STREAM_ID_WIDTH;
    localparam int ENTRY_W     = 128 + STREAM_ID_WIDTH;
    localparam int CNT_W       = 8;

    localparam logic [REQ_FIFO_DEPTH_LG2:0] REQ_FULL = (REQ_FIFO_DEPTH_LG2+1)'(REQ_FIFO_DEPTH);
    localparam logic [RSP_FIFO_DEPTH_LG2:0] RSP_FULL = (RSP_FIFO_DEPTH_LG2+1)'(RSP_FIFO_DEPTH);
    localparam logic [CNT_W-1:0]            OUT_CAP  = CNT_W'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]            r_req_mem [REQ_FIFO_DEPTH];
    logic [REQ_FIFO_DEPTH_LG2-1:0] r_req_wr_ptr;
    logic [REQ_FIFO_DEPTH_LG2-1:0] r_req_rd_ptr;
    logic [REQ_FIFO_DEPTH_LG2:0]   r_req_count;

    logic                          w_req_push;
    logic                          w_req_pop;
    logic                          w_req_empty;
    logic [ENTRY_W-1:0]            w_host_entry;
    logic [ENTRY_W-1:0]            w_head_entry;
    logic [STREAM_ID_WIDTH-1:0]    w_head_sid;
    logic                          w_head_below_cap;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [STREAM_ID_WIDTH-1:0]    r_rsp_mem [RSP_FIFO_DEPTH];
    logic [RSP_FIFO_DEPTH_LG2-1:0] r_rsp_wr_ptr;
    logic [RSP_FIFO_DEPTH_LG2-1:0] r_rsp_rd_ptr;
    logic [RSP_FIFO_DEPTH_LG2:0]   r_rsp_count;

    logic                          w_rsp_push;
    logic                          w_rsp_pop;
    logic                          w_rsp_empty;

    // ------------------------------------------------------------------
    // Per-stream outstanding counters and error flag
    // ------------------------------------------------------------------
    logic [NUM_STREAMS-1:0][CNT_W-1:0] w_out_cnt;
    logic [NUM_STREAMS-1:0]            w_out_nonzero;
    logic                              w_cpl_on_zero;
    logic                              r_err;

    // ---------------- request FIFO ----------------
    assign w_host_entry = {host_opcode_i, host_dst0_i, host_src0_i, host_src1_i,
                           host_src2_i, host_imm_i, host_stream_id_i};

    assign w_req_empty  = (r_req_count == '0);
    assign host_ready_o = (r_req_count < REQ_FULL);
    assign w_req_push   = host_valid_i && host_ready_o;

    assign w_head_entry = r_req_mem[r_req_rd_ptr];
    assign w_head_sid   = w_head_entry[STREAM_ID_WIDTH-1:0];

    // The storage under an empty FIFO is stale. That is harmless because
    // the empty term already forces core_valid_o low.
    assign w_head_below_cap = (w_out_cnt[w_head_sid] < OUT_CAP);
    assign core_valid_o     = !w_req_empty && w_head_below_cap;
    assign w_req_pop        = core_valid_o && core_ready_i;

    assign {core_opcode_o, core_dst0_o, core_src0_o, core_src1_o,
            core_src2_o, core_imm_o, core_stream_id_o} = w_head_entry;

    // Storage carries no reset. Only the pointers and count define which
    // entries are valid.
    always_ff @(posedge clk) begin
        if (w_req_push) begin
            r_req_mem[r_req_wr_ptr] <= w_host_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_wr_ptr <= '0;
            r_req_rd_ptr <= '0;
            r_req_count  <= '0;
        end else begin
            if (w_req_push) begin
                r_req_wr_ptr <= r_req_wr_ptr + REQ_FIFO_DEPTH_LG2'(1);
            end
            if (w_req_pop) begin
                r_req_rd_ptr <= r_req_rd_ptr + REQ_FIFO_DEPTH_LG2'(1);
            end
            case ({w_req_push, w_req_pop})
                2'b10:   r_req_count <= r_req_count + (REQ_FIFO_DEPTH_LG2+1)'(1);
                2'b01:   r_req_count <= r_req_count - (REQ_FIFO_DEPTH_LG2+1)'(1);
                default: r_req_count <= r_req_count;
            endcase
        end
    end

    assign req_count_o = r_req_count;

    // ---------------- response FIFO ----------------
    assign w_rsp_empty          = (r_rsp_count == '0);
    assign core_rsp_ready_o     = (r_rsp_count < RSP_FULL);
    assign w_rsp_push           = core_rsp_valid_i && core_rsp_ready_o;
    assign host_rsp_valid_o     = !w_rsp_empty;
    assign host_rsp_stream_id_o = r_rsp_mem[r_rsp_rd_ptr];
    assign w_rsp_pop            = host_rsp_valid_o && host_rsp_ready_i;

    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wr_ptr] <= core_rsp_stream_id_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_wr_ptr <= '0;
            r_rsp_rd_ptr <= '0;
            r_rsp_count  <= '0;
        end else begin
            if (w_rsp_push) begin
                r_rsp_wr_ptr <= r_rsp_wr_ptr + RSP_FIFO_DEPTH_LG2'(1);
            end
            if (w_rsp_pop) begin
                r_rsp_rd_ptr <= r_rsp_rd_ptr + RSP_FIFO_DEPTH_LG2'(1);
            end
            case ({w_rsp_push, w_rsp_pop})
                2'b10:   r_rsp_count <= r_rsp_count + (RSP_FIFO_DEPTH_LG2+1)'(1);
                2'b01:   r_rsp_count <= r_rsp_count - (RSP_FIFO_DEPTH_LG2+1)'(1);
                default: r_rsp_count <= r_rsp_count;
            endcase
        end
    end

    // ---------------- outstanding counters ----------------
    // An issue and a completion on the same stream in the same cycle
    // cancel out. A completion on a stream with nothing outstanding leaves
    // its counter at zero; the error flag records the event instead.
    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_stream
        logic             w_inc;
        logic             w_dec;
        logic [CNT_W-1:0] r_cnt;

        assign w_inc = w_req_pop  && (w_head_sid == STREAM_ID_WIDTH'(g));
        assign w_dec = w_rsp_push && (core_rsp_stream_id_i == STREAM_ID_WIDTH'(g));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end

        assign w_out_cnt[g]     = r_cnt;
        assign w_out_nonzero[g] = (r_cnt != '0);
    end

    assign w_cpl_on_zero = w_rsp_push && (w_out_cnt[core_rsp_stream_id_i] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_cpl_on_zero) begin
            r_err <= 1'b1;
        end
    end

    assign err_o  = r_err;
    assign busy_o = !w_req_empty || !w_rsp_empty || (|w_out_nonzero);

endmodule

// File: tb/tb_vpu_host_if_bridge.sv
module tb_vpu_host_if_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_valid_i;
    logic        host_ready_o;
    logic [7:0]  host_opcode_i;
    logic [23:0] host_dst0_i, host_src0_i, host_src1_i, host_src2_i, host_imm_i;
    logic [1:0]  host_stream_id_i;
    logic        host_rsp_valid_o;
    logic [1:0]  host_rsp_stream_id_o;
    logic        host_rsp_ready_i;
    logic        core_valid_o;
    logic        core_ready_i;
    logic [7:0]  core_opcode_o;
    logic [23:0] core_dst0_o, core_src0_o, core_src1_o, core_src2_o, core_imm_o;
    logic [1:0]  core_stream_id_o;
    logic        core_rsp_valid_i;
    logic [1:0]  core_rsp_stream_id_i;
    logic        core_rsp_ready_o;
    logic [2:0]  req_count_o;
    logic        busy_o;
    logic        err_o;

    logic [129:0] core_entry;
    assign core_entry = {core_opcode_o, core_dst0_o, core_src0_o, core_src1_o,
                         core_src2_o, core_imm_o, core_stream_id_o};

    vpu_host_if_bridge dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .host_valid_i         (host_valid_i),
        .host_ready_o         (host_ready_o),
        .host_opcode_i        (host_opcode_i),
        .host_dst0_i          (host_dst0_i),
        .host_src0_i          (host_src0_i),
        .host_src1_i          (host_src1_i),
        .host_src2_i          (host_src2_i),
        .host_imm_i           (host_imm_i),
        .host_stream_id_i     (host_stream_id_i),
        .host_rsp_valid_o     (host_rsp_valid_o),
        .host_rsp_stream_id_o (host_rsp_stream_id_o),
        .host_rsp_ready_i     (host_rsp_ready_i),
        .core_valid_o         (core_valid_o),
        .core_ready_i         (core_ready_i),
        .core_opcode_o        (core_opcode_o),
        .core_dst0_o          (core_dst0_o),
        .core_src0_o          (core_src0_o),
        .core_src1_o          (core_src1_o),
        .core_src2_o          (core_src2_o),
        .core_imm_o           (core_imm_o),
        .core_stream_id_o     (core_stream_id_o),
        .core_rsp_valid_i     (core_rsp_valid_i),
        .core_rsp_stream_id_i (core_rsp_stream_id_i),
        .core_rsp_ready_o     (core_rsp_ready_o),
        .req_count_o          (req_count_o),
        .busy_o               (busy_o),
        .err_o                (err_o)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: request queue of packed entries, completion queue,
    // in-flight count per stream, sticky error bit.
    logic [129:0] m_req[$];
    logic [1:0]   m_rsp[$];
    int           m_out[4];
    bit           m_err;
    bit           last_push;
    bit           last_cpl;

    function automatic bit m_host_ready();
        return m_req.size() < 4;
    endfunction

    function automatic bit m_core_valid();
        if (m_req.size() == 0) return 1'b0;
        return m_out[m_req[0][1:0]] < 3;
    endfunction

    function automatic bit m_busy();
        bit b;
        b = (m_req.size() != 0) || (m_rsp.size() != 0);
        for (int s = 0; s < 4; s++) if (m_out[s] != 0) b = 1'b1;
        return b;
    endfunction

    function automatic logic [129:0] host_entry();
        return {host_opcode_i, host_dst0_i, host_src0_i, host_src1_i,
                host_src2_i, host_imm_i, host_stream_id_i};
    endfunction

    task automatic model_clear();
        m_req.delete();
        m_rsp.delete();
        for (int s = 0; s < 4; s++) m_out[s] = 0;
        m_err     = 1'b0;
        last_push = 1'b0;
        last_cpl  = 1'b0;
    endtask

    // Advance one clock; the model applies the transfers its own state says
    // happen at that edge.
    task automatic tick();
        bit           push, issue, cpl, hpop;
        logic [1:0]   isid, csid;
        logic [129:0] pent;
        push  = host_valid_i && m_host_ready();
        pent  = host_entry();
        issue = core_ready_i && m_core_valid();
        isid  = issue ? m_req[0][1:0] : 2'd0;
        cpl   = core_rsp_valid_i && (m_rsp.size() < 4);
        csid  = core_rsp_stream_id_i;
        hpop  = host_rsp_ready_i && (m_rsp.size() != 0);
        @(posedge clk);
        #1;
        if (issue) void'(m_req.pop_front());
        if (push)  m_req.push_back(pent);
        if (hpop)  void'(m_rsp.pop_front());
        if (cpl) begin
            m_rsp.push_back(csid);
            if (m_out[csid] == 0) m_err = 1'b1;
        end
        for (int s = 0; s < 4; s++) begin
            bit inc, dec;
            inc = issue && (isid == 2'(s));
            dec = cpl && (csid == 2'(s));
            if (inc && !dec) m_out[s]++;
            else if (dec && !inc && m_out[s] > 0) m_out[s]--;
        end
        last_push = push;
        last_cpl  = cpl;
    endtask

    task automatic set_req(input logic [7:0] op, input logic [1:0] sid);
        host_valid_i     = 1'b1;
        host_opcode_i    = op;
        host_dst0_i      = 24'($urandom());
        host_src0_i      = 24'($urandom());
        host_src1_i      = 24'($urandom());
        host_src2_i      = 24'($urandom());
        host_imm_i       = 24'($urandom());
        host_stream_id_i = sid;
    endtask

    task automatic clear_inputs();
        host_valid_i         = 1'b0;
        host_opcode_i        = '0;
        host_dst0_i          = '0;
        host_src0_i          = '0;
        host_src1_i          = '0;
        host_src2_i          = '0;
        host_imm_i           = '0;
        host_stream_id_i     = '0;
        host_rsp_ready_i     = 1'b0;
        core_ready_i         = 1'b0;
        core_rsp_valid_i     = 1'b0;
        core_rsp_stream_id_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_clear();
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Pushes the stream list in order, holding each request until accepted,
    // for a fixed number of cycles; returns how many issues were seen.
    task automatic push_list(input logic [1:0] sids[$], input int cycles, output int issues);
        int idx;
        idx    = 0;
        issues = 0;
        for (int c = 0; c < cycles; c++) begin
            if (idx < sids.size()) begin
                if (!host_valid_i || last_push) set_req(8'($urandom()), sids[idx]);
            end else begin
                host_valid_i = 1'b0;
            end
            if (core_valid_o && core_ready_i) issues++;
            tick();
            if (last_push && idx < sids.size()) idx++;
        end
        host_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_clear();
        #2;
        vectors++; if (host_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_host_ready got=%0b exp=1", host_ready_o); end
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_core_valid got=%0b exp=0", core_valid_o); end
        vectors++; if (host_rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%0b exp=0", host_rsp_valid_o); end
        vectors++; if (core_rsp_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_core_rsp_ready got=%0b exp=1", core_rsp_ready_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        vectors++; if (req_count_o !== 3'd0) begin miscompares++; $display("FAIL reset_req_count got=%0d exp=0", req_count_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%0b exp=0", err_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [129:0] exp_e;
        do_reset();
        core_ready_i = 1'b1;
        set_req(8'h11, 2'd1);
        exp_e = host_entry();
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass got=%0b exp=0", core_valid_o); end
        tick();
        host_valid_i = 1'b0;
        vectors++; if (core_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_core_valid got=%0b exp=1", core_valid_o); end
        vectors++; if (core_entry !== exp_e) begin miscompares++; $display("FAIL single_fields got=%h exp=%h", core_entry, exp_e); end
        tick();
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_after_issue got=%0b exp=0", core_valid_o); end
        core_rsp_valid_i     = 1'b1;
        core_rsp_stream_id_i = 2'd1;
        vectors++; if (host_rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_rsp_no_bypass got=%0b exp=0", host_rsp_valid_o); end
        tick();
        core_rsp_valid_i = 1'b0;
        vectors++; if (host_rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_rsp_valid got=%0b exp=1", host_rsp_valid_o); end
        vectors++; if (host_rsp_stream_id_o !== 2'd1) begin miscompares++; $display("FAIL single_rsp_sid got=%0d exp=1", host_rsp_stream_id_o); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy_pending got=%0b exp=1", busy_o); end
        host_rsp_ready_i = 1'b1;
        tick();
        host_rsp_ready_i = 1'b0;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle got=%0b exp=0", busy_o); end
        vectors++; if (host_rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_rsp_drained got=%0b exp=0", host_rsp_valid_o); end
    endtask

    task automatic test_req_fill();
        do_reset();
        host_rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(8'(8'hA0 + i), 2'(i));
            tick();
        end
        host_valid_i = 1'b0;
        vectors++; if (req_count_o !== 3'd4) begin miscompares++; $display("FAIL fill_count got=%0d exp=4", req_count_o); end
        vectors++; if (host_ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_host_ready got=%0b exp=0", host_ready_o); end
        core_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (core_valid_o !== 1'b1 || core_opcode_o !== 8'(8'hA0 + i)) begin miscompares++; $display("FAIL fill_order[%0d] got valid=%0b op=%h exp valid=1 op=%h", i, core_valid_o, core_opcode_o, 8'(8'hA0 + i)); end
            tick();
            if (i == 0) begin
                vectors++; if (host_ready_o !== 1'b1) begin miscompares++; $display("FAIL fill_ready_after_pop got=%0b exp=1", host_ready_o); end
            end
        end
        vectors++; if (req_count_o !== 3'd0) begin miscompares++; $display("FAIL fill_drained got=%0d exp=0", req_count_o); end
    endtask

    task automatic test_cap();
        int issues;
        do_reset();
        core_ready_i     = 1'b1;
        host_rsp_ready_i = 1'b1;
        push_list('{2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, 12, issues);
        vectors++; if (issues !== 3) begin miscompares++; $display("FAIL cap_issues got=%0d exp=3", issues); end
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL cap_blocked got=%0b exp=0", core_valid_o); end
        vectors++; if (req_count_o !== 3'd2) begin miscompares++; $display("FAIL cap_count got=%0d exp=2", req_count_o); end
        core_rsp_valid_i     = 1'b1;
        core_rsp_stream_id_i = 2'd2;
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL cap_no_same_cycle got=%0b exp=0", core_valid_o); end
        tick();
        core_rsp_valid_i = 1'b0;
        vectors++; if (core_valid_o !== 1'b1 || core_stream_id_o !== 2'd2) begin miscompares++; $display("FAIL cap_unblock got valid=%0b sid=%0d exp valid=1 sid=2", core_valid_o, core_stream_id_o); end
        tick();
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL cap_reblock got=%0b exp=0", core_valid_o); end
    endtask

    task automatic test_hol();
        int   issues;
        do_reset();
        core_ready_i     = 1'b1;
        host_rsp_ready_i = 1'b1;
        push_list('{2'd0, 2'd0, 2'd0, 2'd0, 2'd3}, 12, issues);
        vectors++; if (issues !== 3) begin miscompares++; $display("FAIL hol_issues got=%0d exp=3", issues); end
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL hol_blocked got=%0b exp=0", core_valid_o); end
        vectors++; if (req_count_o !== 3'd2) begin miscompares++; $display("FAIL hol_count got=%0d exp=2", req_count_o); end
        core_rsp_valid_i     = 1'b1;
        core_rsp_stream_id_i = 2'd0;
        tick();
        core_rsp_valid_i = 1'b0;
        vectors++; if (core_valid_o !== 1'b1 || core_stream_id_o !== 2'd0) begin miscompares++; $display("FAIL hol_head got valid=%0b sid=%0d exp valid=1 sid=0", core_valid_o, core_stream_id_o); end
        tick();
        vectors++; if (core_valid_o !== 1'b1 || core_stream_id_o !== 2'd3) begin miscompares++; $display("FAIL hol_younger got valid=%0b sid=%0d exp valid=1 sid=3", core_valid_o, core_stream_id_o); end
        tick();
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL hol_empty got=%0b exp=0", core_valid_o); end
    endtask

    task automatic test_back_to_back();
        int           issues;
        logic [1:0]   cpl_sids[3];
        do_reset();
        core_ready_i = 1'b1;
        push_list('{2'd0, 2'd0, 2'd1, 2'd1}, 8, issues);
        vectors++; if (issues !== 4) begin miscompares++; $display("FAIL bp_initial_issues got=%0d exp=4", issues); end
        cpl_sids = '{2'd0, 2'd0, 2'd1};
        for (int k = 0; k < 3; k++) begin
            core_rsp_valid_i     = 1'b1;
            core_rsp_stream_id_i = cpl_sids[k];
            tick();
        end
        core_rsp_valid_i = 1'b0;
        vectors++; if (core_rsp_ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_three_buffered got=%0b exp=1", core_rsp_ready_o); end
        set_req(8'h5A, 2'd1);
        tick();
        host_valid_i = 1'b0;
        vectors++; if (core_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_simul_head got=%0b exp=1", core_valid_o); end
        core_rsp_valid_i     = 1'b1;
        core_rsp_stream_id_i = 2'd1;
        tick();
        core_rsp_valid_i = 1'b0;
        vectors++; if (core_rsp_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_rsp_full got=%0b exp=0", core_rsp_ready_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL bp_no_err got=%0b exp=0", err_o); end
        // stream 1 still holds one in flight, so only two more fit under the cap
        push_list('{2'd1, 2'd1, 2'd1}, 8, issues);
        vectors++; if (issues !== 2) begin miscompares++; $display("FAIL bp_simul_unchanged got=%0d exp=2", issues); end
        vectors++; if (req_count_o !== 3'd1) begin miscompares++; $display("FAIL bp_count got=%0d exp=1", req_count_o); end
        core_rsp_valid_i     = 1'b1;
        core_rsp_stream_id_i = 2'd1;
        tick();
        vectors++; if (core_rsp_ready_o !== 1'b0 || core_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_held got rsp_ready=%0b core_valid=%0b exp 0 0", core_rsp_ready_o, core_valid_o); end
        host_rsp_ready_i = 1'b1;
        tick();
        host_rsp_ready_i = 1'b0;
        vectors++; if (core_rsp_ready_o !== 1'b1 || core_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_space got rsp_ready=%0b core_valid=%0b exp 1 0", core_rsp_ready_o, core_valid_o); end
        tick();
        core_rsp_valid_i = 1'b0;
        vectors++; if (core_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_unblock got=%0b exp=1", core_valid_o); end
    endtask

    task automatic test_error_reset();
        do_reset();
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_initial got=%0b exp=0", err_o); end
        core_rsp_valid_i     = 1'b1;
        core_rsp_stream_id_i = 2'd3;
        tick();
        core_rsp_valid_i = 1'b0;
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_set got=%0b exp=1", err_o); end
        vectors++; if (host_rsp_valid_o !== 1'b1 || host_rsp_stream_id_o !== 2'd3) begin miscompares++; $display("FAIL err_pushed got valid=%0b sid=%0d exp valid=1 sid=3", host_rsp_valid_o, host_rsp_stream_id_o); end
        for (int i = 0; i < 3; i++) begin
            set_req(8'($urandom()), 2'(i));
            tick();
        end
        vectors++; if (err_o !== 1'b1 || req_count_o !== 3'd3) begin miscompares++; $display("FAIL err_sticky got err=%0b count=%0d exp err=1 count=3", err_o, req_count_o); end
        set_req(8'h77, 2'd3);
        rst_n = 1'b0;
        model_clear();
        #2;
        vectors++; if (host_ready_o !== 1'b1) begin miscompares++; $display("FAIL areset_host_ready got=%0b exp=1", host_ready_o); end
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL areset_core_valid got=%0b exp=0", core_valid_o); end
        vectors++; if (host_rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL areset_rsp_valid got=%0b exp=0", host_rsp_valid_o); end
        vectors++; if (core_rsp_ready_o !== 1'b1) begin miscompares++; $display("FAIL areset_core_rsp_ready got=%0b exp=1", core_rsp_ready_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL areset_busy got=%0b exp=0", busy_o); end
        vectors++; if (req_count_o !== 3'd0) begin miscompares++; $display("FAIL areset_count got=%0d exp=0", req_count_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL areset_err got=%0b exp=0", err_o); end
        host_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++; if (req_count_o !== 3'd0 || err_o !== 1'b0) begin miscompares++; $display("FAIL areset_release got count=%0d err=%0b exp 0 0", req_count_o, err_o); end
    endtask

    task automatic test_random();
        logic [1:0] s;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!host_valid_i || last_push) begin
                if (($urandom() % 3) != 0) set_req(8'($urandom()), 2'($urandom()));
                else host_valid_i = 1'b0;
            end
            core_ready_i     = ($urandom() % 4) != 0;
            host_rsp_ready_i = ($urandom() % 3) != 0;
            if (!core_rsp_valid_i || last_cpl) begin
                s = 2'($urandom());
                if (m_out[s] > 0 && ($urandom() % 2) == 0) begin
                    core_rsp_valid_i     = 1'b1;
                    core_rsp_stream_id_i = s;
                end else begin
                    core_rsp_valid_i = 1'b0;
                end
            end
            vectors++; if (host_ready_o !== m_host_ready()) begin miscompares++; $display("FAIL rnd_host_ready c=%0d got=%0b exp=%0b", c, host_ready_o, m_host_ready()); end
            vectors++; if (core_valid_o !== m_core_valid()) begin miscompares++; $display("FAIL rnd_core_valid c=%0d got=%0b exp=%0b", c, core_valid_o, m_core_valid()); end
            if (m_core_valid()) begin
                vectors++; if (core_entry !== m_req[0]) begin miscompares++; $display("FAIL rnd_core_entry c=%0d got=%h exp=%h", c, core_entry, m_req[0]); end
            end
            vectors++; if (core_rsp_ready_o !== (m_rsp.size() < 4)) begin miscompares++; $display("FAIL rnd_core_rsp_ready c=%0d got=%0b exp=%0b", c, core_rsp_ready_o, m_rsp.size() < 4); end
            vectors++; if (host_rsp_valid_o !== (m_rsp.size() != 0)) begin miscompares++; $display("FAIL rnd_rsp_valid c=%0d got=%0b exp=%0b", c, host_rsp_valid_o, m_rsp.size() != 0); end
            if (m_rsp.size() != 0) begin
                vectors++; if (host_rsp_stream_id_o !== m_rsp[0]) begin miscompares++; $display("FAIL rnd_rsp_sid c=%0d got=%0d exp=%0d", c, host_rsp_stream_id_o, m_rsp[0]); end
            end
            vectors++; if (req_count_o !== 3'(m_req.size())) begin miscompares++; $display("FAIL rnd_req_count c=%0d got=%0d exp=%0d", c, req_count_o, m_req.size()); end
            vectors++; if (busy_o !== m_busy()) begin miscompares++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy_o, m_busy()); end
            vectors++; if (err_o !== m_err) begin miscompares++; $display("FAIL rnd_err c=%0d got=%0b exp=%0b", c, err_o, m_err); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_req_fill();
        test_cap();
        test_hol();
        test_back_to_back();
        test_error_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
